// File: rtl/memory_writeback_pipe_if.sv
// MEM->WB pipeline bus.
// Groups the stage-control inputs (stall, flush), the memory-stage
// instruction slot and the writeback-side results into one bundle.
//   master : drives the memory-stage side, observes the writeback side
//   slave  : the pipe itself; consumes the memory side, drives writeback
interface memory_writeback_pipe_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
);
  // control
  logic                   stall;
  logic                   flush;
  // memory-stage slot
  logic                   valid_memory;
  logic [DATA_WIDTH-1:0]  ALU_result_memory;
  logic [DATA_WIDTH-1:0]  load_data_memory;
  logic [DATA_WIDTH-1:0]  lbr_data_memory;
  logic                   opwrite_memory;
  logic [1:0]             opsel_memory;
  logic [4:0]             opReg_memory;
  logic [DATA_WIDTH-1:0]  instruction_memory;
  // writeback side
  logic [DATA_WIDTH-1:0]  ALU_result_writeback;
  logic [DATA_WIDTH-1:0]  load_data_writeback;
  logic [DATA_WIDTH-1:0]  lbr_data_writeback;
  logic                   opwrite_writeback;
  logic [1:0]             opsel_writeback;
  logic [4:0]             opReg_writeback;
  logic [DATA_WIDTH-1:0]  instruction_writeback;
  logic                   valid_writeback;
  logic [DATA_WIDTH-1:0]  wb_data_writeback;
  logic [COUNT_WIDTH-1:0] retired_count;

  modport master (
    output stall, flush, valid_memory, ALU_result_memory, load_data_memory,
           lbr_data_memory, opwrite_memory, opsel_memory, opReg_memory,
           instruction_memory,
    input  ALU_result_writeback, load_data_writeback, lbr_data_writeback,
           opwrite_writeback, opsel_writeback, opReg_writeback,
           instruction_writeback, valid_writeback, wb_data_writeback,
           retired_count
  );

  modport slave (
    input  stall, flush, valid_memory, ALU_result_memory, load_data_memory,
           lbr_data_memory, opwrite_memory, opsel_memory, opReg_memory,
           instruction_memory,
    output ALU_result_writeback, load_data_writeback, lbr_data_writeback,
           opwrite_writeback, opsel_writeback, opReg_writeback,
           instruction_writeback, valid_writeback, wb_data_writeback,
           retired_count
  );
endinterface

// File: rtl/memory_writeback_pipe.sv
// MEM->WB pipeline register chain of PIPE_DEPTH stages.
// Each stage carries a valid bit plus the instruction payload. The chain
// holds on stall, turns every stage into a bubble on flush, presents a
// pre-muxed writeback value from the last stage and counts retirements.
// Ports:
//   clock  : rising-edge clock for all state
//   reset  : synchronous, active-high; clears every stage and the counter
//   bus    : memory_writeback_pipe_if.slave (stall/flush, memory-stage
//            slot in, writeback-stage fields, wb_data, retired_count out)
// Edge priority: reset > flush > stall > advance.
module memory_writeback_pipe #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDRESS_BITS = 20,
  parameter int                    PIPE_DEPTH   = 1,
  parameter int                    COUNT_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] NOP          = DATA_WIDTH'(32'h00000013)
) (
  input logic                   clock,
  input logic                   reset,
  memory_writeback_pipe_if.slave bus
);

  // Depth check at elaboration; ADDRESS_BITS only exists for port-list
  // parity with the other pipe units, so it is merely sanity-checked here.
  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("memory_writeback_pipe: PIPE_DEPTH must be in 1..4");
  end
  if (ADDRESS_BITS < 1) begin : g_bad_addr
    $error("memory_writeback_pipe: ADDRESS_BITS must be positive");
  end

  typedef struct packed {
    logic                  opwrite;
    logic [1:0]            opsel;
    logic [4:0]            op_reg;
    logic [DATA_WIDTH-1:0] alu;
    logic [DATA_WIDTH-1:0] load;
    logic [DATA_WIDTH-1:0] lbr;
    logic [DATA_WIDTH-1:0] instr;
  } stage_t;

  localparam stage_t BUBBLE = '{
    opwrite: 1'b0,
    opsel:   2'b00,
    op_reg:  5'd0,
    alu:     '0,
    load:    '0,
    lbr:     '0,
    instr:   NOP
  };

  stage_t                 stg_in;
  stage_t                 stg [1:PIPE_DEPTH];
  logic [PIPE_DEPTH:1]    vld_pipe;
  logic [COUNT_WIDTH-1:0] retired;
  logic                   advance;

  assign advance = !bus.flush && !bus.stall;

  always_comb begin
    stg_in.opwrite = bus.opwrite_memory;
    stg_in.opsel   = bus.opsel_memory;
    stg_in.op_reg  = bus.opReg_memory;
    stg_in.alu     = bus.ALU_result_memory;
    stg_in.load    = bus.load_data_memory;
    stg_in.lbr     = bus.lbr_data_memory;
    stg_in.instr   = bus.instruction_memory;
  end

  // Reset and flush load identical bubble contents; they only differ in
  // their effect on the retirement counter.
  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      for (int i = 1; i <= PIPE_DEPTH; i++) begin
        stg[i]      <= BUBBLE;
        vld_pipe[i] <= 1'b0;
      end
    end else if (!bus.stall) begin
      stg[1]      <= stg_in;
      vld_pipe[1] <= bus.valid_memory;
      for (int i = 2; i <= PIPE_DEPTH; i++) begin
        stg[i]      <= stg[i-1];
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  // An instruction retires on the edge that pushes it out of the last
  // stage, so each one is counted exactly once. Wraps freely.
  always_ff @(posedge clock) begin
    if (reset) begin
      retired <= '0;
    end else if (advance && vld_pipe[PIPE_DEPTH]) begin
      retired <= retired + COUNT_WIDTH'(1);
    end
  end

  // Writeback value comes from registers only; bubbles give 0.
  always_comb begin
    bus.wb_data_writeback = '0;
    if (vld_pipe[PIPE_DEPTH]) begin
      case (stg[PIPE_DEPTH].opsel)
        2'b00:   bus.wb_data_writeback = stg[PIPE_DEPTH].alu;
        2'b01:   bus.wb_data_writeback = stg[PIPE_DEPTH].load;
        2'b10:   bus.wb_data_writeback = stg[PIPE_DEPTH].lbr;
        default: bus.wb_data_writeback = '0;
      endcase
    end
  end

  assign bus.ALU_result_writeback  = stg[PIPE_DEPTH].alu;
  assign bus.load_data_writeback   = stg[PIPE_DEPTH].load;
  assign bus.lbr_data_writeback    = stg[PIPE_DEPTH].lbr;
  assign bus.opwrite_writeback     = stg[PIPE_DEPTH].opwrite & vld_pipe[PIPE_DEPTH];
  assign bus.opsel_writeback       = stg[PIPE_DEPTH].opsel;
  assign bus.opReg_writeback       = stg[PIPE_DEPTH].op_reg;
  assign bus.instruction_writeback = stg[PIPE_DEPTH].instr;
  assign bus.valid_writeback       = vld_pipe[PIPE_DEPTH];
  assign bus.retired_count         = retired;

endmodule

// File: tb/tb_memory_writeback_pipe.sv
// Bench for memory_writeback_pipe. Two instances share one stimulus:
// d1 (PIPE_DEPTH=1, COUNT_WIDTH=4) and d3 (PIPE_DEPTH=3, COUNT_WIDTH=32).
// A queue model per instance (one entry per in-flight slot) is checked
// every cycle; directed literal checks pin the model at key points.
module tb_memory_writeback_pipe;

  typedef struct packed {
    logic        valid;
    logic        opwrite;
    logic [1:0]  opsel;
    logic [4:0]  opreg;
    logic [31:0] alu;
    logic [31:0] load;
    logic [31:0] lbr;
    logic [31:0] instr;
  } rec_t;

  localparam rec_t BUB = '{valid: 1'b0, opwrite: 1'b0, opsel: 2'b00,
                           opreg: 5'd0, alu: 32'h0, load: 32'h0, lbr: 32'h0,
                           instr: 32'h00000013};

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  rec_t in_rec = BUB;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  always #5 clock = ~clock;

  memory_writeback_pipe_if #(.DATA_WIDTH(32), .COUNT_WIDTH(4))  if1 ();
  memory_writeback_pipe_if #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) if3 ();

  assign if1.stall = stall;               assign if3.stall = stall;
  assign if1.flush = flush;               assign if3.flush = flush;
  assign if1.valid_memory = in_rec.valid; assign if3.valid_memory = in_rec.valid;
  assign if1.ALU_result_memory = in_rec.alu;   assign if3.ALU_result_memory = in_rec.alu;
  assign if1.load_data_memory  = in_rec.load;  assign if3.load_data_memory  = in_rec.load;
  assign if1.lbr_data_memory   = in_rec.lbr;   assign if3.lbr_data_memory   = in_rec.lbr;
  assign if1.opwrite_memory = in_rec.opwrite;  assign if3.opwrite_memory = in_rec.opwrite;
  assign if1.opsel_memory   = in_rec.opsel;    assign if3.opsel_memory   = in_rec.opsel;
  assign if1.opReg_memory   = in_rec.opreg;    assign if3.opReg_memory   = in_rec.opreg;
  assign if1.instruction_memory = in_rec.instr; assign if3.instruction_memory = in_rec.instr;

  memory_writeback_pipe #(.DATA_WIDTH(32), .ADDRESS_BITS(20), .PIPE_DEPTH(1),
                          .COUNT_WIDTH(4), .NOP(32'h00000013))
    d1 (.clock(clock), .reset(rst), .bus(if1));

  memory_writeback_pipe #(.DATA_WIDTH(32), .ADDRESS_BITS(20), .PIPE_DEPTH(3),
                          .COUNT_WIDTH(32), .NOP(32'h00000013))
    d3 (.clock(clock), .reset(rst), .bus(if3));

  // ---------------- model ----------------
  // q[0] is the newest slot, q[$] the one presented at the outputs.
  rec_t q1[$];
  rec_t q3[$];
  int   c1 = 0;
  int   c3 = 0;

  function automatic logic [31:0] exp_wb(rec_t r);
    if (!r.valid) return 32'h0;
    case (r.opsel)
      2'b00:   return r.alu;
      2'b01:   return r.load;
      2'b10:   return r.lbr;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (rst) begin
      q1.delete(); q3.delete();
      q1.push_back(BUB);
      for (int i = 0; i < 3; i++) q3.push_back(BUB);
      c1 = 0; c3 = 0;
      chk_en = 1;
    end else if (chk_en) begin
      if (flush) begin
        for (int i = 0; i < q1.size(); i++) q1[i] = BUB;
        for (int i = 0; i < q3.size(); i++) q3[i] = BUB;
      end else if (!stall) begin
        if (q1[$].valid) c1++;
        if (q3[$].valid) c3++;
        void'(q1.pop_back()); q1.push_front(in_rec);
        void'(q3.pop_back()); q3.push_front(in_rec);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(string tag, rec_t e, logic [31:0] cexp,
                     logic [31:0] alu, logic [31:0] load, logic [31:0] lbr,
                     logic ow, logic [1:0] os, logic [4:0] rg,
                     logic [31:0] ins, logic v, logic [31:0] wb,
                     logic [31:0] cnt);
    chk({tag, "_alu"},   alu,  e.alu);
    chk({tag, "_load"},  load, e.load);
    chk({tag, "_lbr"},   lbr,  e.lbr);
    chk({tag, "_opw"},   {31'b0, ow}, {31'b0, e.opwrite & e.valid});
    chk({tag, "_opsel"}, {30'b0, os}, {30'b0, e.opsel});
    chk({tag, "_opreg"}, {27'b0, rg}, {27'b0, e.opreg});
    chk({tag, "_instr"}, ins,  e.instr);
    chk({tag, "_valid"}, {31'b0, v},  {31'b0, e.valid});
    chk({tag, "_wb"},    wb,   exp_wb(e));
    chk({tag, "_cnt"},   cnt,  cexp);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("m1", q1[$], 32'(c1) & 32'hF,
          if1.ALU_result_writeback, if1.load_data_writeback, if1.lbr_data_writeback,
          if1.opwrite_writeback, if1.opsel_writeback, if1.opReg_writeback,
          if1.instruction_writeback, if1.valid_writeback, if1.wb_data_writeback,
          {28'b0, if1.retired_count});
      cmp("m3", q3[$], 32'(c3),
          if3.ALU_result_writeback, if3.load_data_writeback, if3.lbr_data_writeback,
          if3.opwrite_writeback, if3.opsel_writeback, if3.opReg_writeback,
          if3.instruction_writeback, if3.valid_writeback, if3.wb_data_writeback,
          if3.retired_count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic put(logic v, logic w, logic [1:0] s, logic [4:0] rg,
                     logic [31:0] a, logic [31:0] l, logic [31:0] b,
                     logic [31:0] ins);
    in_rec = '{valid: v, opwrite: w, opsel: s, opreg: rg,
               alu: a, load: l, lbr: b, instr: ins};
  endtask

  initial begin
    // reset, two cycles
    rst = 1'b1;
    step(); step();
    chk("rst_instr1", if1.instruction_writeback, 32'h00000013);
    chk("rst_valid1", {31'b0, if1.valid_writeback}, 32'h0);
    chk("rst_cnt1",   {28'b0, if1.retired_count}, 32'h0);
    chk("rst_instr3", if3.instruction_writeback, 32'h00000013);
    rst = 1'b0;

    // I1..I3, back to back
    put(1, 1, 2'b00, 5'd5, 32'h1234, 32'h0, 32'h0, 32'hA1); step();
    chk("i1_wb1",    if1.wb_data_writeback, 32'h1234);
    chk("i1_opw1",   {31'b0, if1.opwrite_writeback}, 32'h1);
    chk("i1_opreg1", {27'b0, if1.opReg_writeback}, 32'h5);
    put(1, 1, 2'b10, 5'd6, 32'h1111, 32'h2222, 32'hDEADBEEF, 32'hA2); step();
    chk("i2_lbr1",   if1.lbr_data_writeback, 32'hDEADBEEF);
    chk("i2_wb1",    if1.wb_data_writeback, 32'hDEADBEEF);
    chk("i2_cnt1",   {28'b0, if1.retired_count}, 32'h1);
    chk("i2_valid3", {31'b0, if3.valid_writeback}, 32'h0);
    put(1, 1, 2'b11, 5'd7, 32'h3333, 32'h4444, 32'h5555, 32'hA3); step();
    chk("i3_wb1",    if1.wb_data_writeback, 32'h0);
    chk("i3_instr3", if3.instruction_writeback, 32'hA1);
    chk("i3_wb3",    if3.wb_data_writeback, 32'h1234);
    put(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h13); step();
    chk("d4_instr3", if3.instruction_writeback, 32'hA2);
    chk("d4_wb3",    if3.wb_data_writeback, 32'hDEADBEEF);
    chk("d4_cnt3",   if3.retired_count, 32'h1);
    step();
    chk("d5_instr3", if3.instruction_writeback, 32'hA3);
    chk("d5_wb3",    if3.wb_data_writeback, 32'h0);
    step();
    chk("d6_cnt3",   if3.retired_count, 32'h3);
    chk("d6_cnt1",   {28'b0, if1.retired_count}, 32'h3);

    // stall while inputs keep changing
    put(1, 1, 2'b00, 5'd8, 32'h101, 32'h0, 32'h0, 32'hB1); step();
    put(1, 1, 2'b00, 5'd8, 32'h102, 32'h0, 32'h0, 32'hB2); step();
    put(1, 1, 2'b00, 5'd8, 32'h103, 32'h0, 32'h0, 32'hB3); step();
    chk("st_pre_instr3", if3.instruction_writeback, 32'hB1);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      put(1, 1, 2'b01, 5'd9, 32'(k), 32'hC00 + 32'(k), 32'(k), 32'hC0 + 32'(k));
      step();
    end
    chk("st_instr3", if3.instruction_writeback, 32'hB1);
    chk("st_cnt3",   if3.retired_count, 32'h3);
    chk("st_instr1", if1.instruction_writeback, 32'hB3);
    chk("st_cnt1",   {28'b0, if1.retired_count}, 32'h5);
    stall = 1'b0;
    put(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h13); step();
    chk("rl_instr3", if3.instruction_writeback, 32'hB2);
    chk("rl_cnt3",   if3.retired_count, 32'h4);
    step();
    chk("rl2_instr3", if3.instruction_writeback, 32'hB3);
    chk("rl2_cnt3",   if3.retired_count, 32'h5);

    // flush together with stall
    put(1, 1, 2'b00, 5'd10, 32'h201, 32'h0, 32'h0, 32'hD1); step();
    put(1, 1, 2'b00, 5'd10, 32'h202, 32'h0, 32'h0, 32'hD2); step();
    chk("fl_pre_cnt3",   if3.retired_count, 32'h6);
    chk("fl_pre_instr1", if1.instruction_writeback, 32'hD2);
    stall = 1'b1; flush = 1'b1;
    put(1, 1, 2'b00, 5'd11, 32'h301, 32'h0, 32'h0, 32'hEE); step();
    stall = 1'b0; flush = 1'b0;
    chk("fl_valid3", {31'b0, if3.valid_writeback}, 32'h0);
    chk("fl_opw3",   {31'b0, if3.opwrite_writeback}, 32'h0);
    chk("fl_instr3", if3.instruction_writeback, 32'h13);
    chk("fl_cnt3",   if3.retired_count, 32'h6);
    chk("fl_valid1", {31'b0, if1.valid_writeback}, 32'h0);
    chk("fl_instr1", if1.instruction_writeback, 32'h13);
    chk("fl_cnt1",   {28'b0, if1.retired_count}, 32'h7);
    // opwrite without valid must not write
    put(0, 1, 2'b00, 5'd12, 32'h401, 32'h0, 32'h0, 32'hF1); step();
    chk("nv_opw1",   {31'b0, if1.opwrite_writeback}, 32'h0);
    chk("nv_wb1",    if1.wb_data_writeback, 32'h0);
    chk("nv_valid3", {31'b0, if3.valid_writeback}, 32'h0);

    // load path
    put(1, 1, 2'b01, 5'd3, 32'hAAAA, 32'hBEEF, 32'h0, 32'hF2); step();
    chk("ld_wb1", if1.wb_data_writeback, 32'hBEEF);

    // reset dominates stall and flush
    rst = 1'b1; stall = 1'b1; flush = 1'b1;
    put(1, 1, 2'b00, 5'd1, 32'h7, 32'h0, 32'h0, 32'h77); step();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    chk("rs_cnt1",   {28'b0, if1.retired_count}, 32'h0);
    chk("rs_cnt3",   if3.retired_count, 32'h0);
    chk("rs_instr1", if1.instruction_writeback, 32'h13);

    // counter wrap on the 4-bit instance
    for (int k = 0; k < 17; k++) begin
      put(1, 1, 2'(k % 3), 5'(k), 32'h500 + 32'(k), 32'h600 + 32'(k),
          32'h700 + 32'(k), 32'hE00 + 32'(k));
      step();
    end
    put(0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h13); step();
    chk("wr_cnt1", {28'b0, if1.retired_count}, 32'h1);
    chk("wr_cnt3", if3.retired_count, 32'd15);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_writeback_pipe.md
Name: memory_writeback_pipe

Overview:
Parametrised MEM->WB pipeline register for the BRISC-V core. It replaces the fixed single-stage latch with a configurable-depth register chain. The chain adds a per-stage valid bit, stall (hold), flush (bubble injection), a pre-muxed writeback/forwarding value and a retired-instruction counter. It sits between the memory stage and the writeback/regfile write port.

Parameters:
DATA_WIDTH, 32, width of data, result and instruction fields
ADDRESS_BITS, 20, kept for interface parity with sibling pipe units; unused internally
PIPE_DEPTH, 1, number of register stages (legal 1..4); latency in cycles
COUNT_WIDTH, 32, width of retired-instruction counter
NOP, 32'h00000013, instruction word loaded on reset/flush

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold all stages; inputs ignored
flush  in  1  convert all stages to bubbles
valid_memory  in  1  memory-stage slot holds a real instruction
ALU_result_memory  in  DATA_WIDTH  ALU result
load_data_memory  in  DATA_WIDTH  load data
lbr_data_memory  in  DATA_WIDTH  LBR data
opwrite_memory  in  1  register write request
opsel_memory  in  2  writeback source select
opReg_memory  in  5  destination register
instruction_memory  in  DATA_WIDTH  instruction word
ALU_result_writeback  out  DATA_WIDTH  final-stage ALU result
load_data_writeback  out  DATA_WIDTH  final-stage load data
lbr_data_writeback  out  DATA_WIDTH  final-stage LBR data
opwrite_writeback  out  1  opwrite AND valid of final stage
opsel_writeback  out  2  final-stage opsel
opReg_writeback  out  5  final-stage destination
instruction_writeback  out  DATA_WIDTH  final-stage instruction
valid_writeback  out  1  final stage holds a real instruction
wb_data_writeback  out  DATA_WIDTH  muxed writeback value
retired_count  out  COUNT_WIDTH  valid instructions retired

Behaviour:
- Reset: synchronous, active-high. Every stage is cleared: data fields 0, opwrite 0, opsel 0, opReg 0, instruction NOP, valid 0. retired_count is 0. All outputs read these values in the cycle after the reset edge.
- Edge priority: reset > flush > stall > advance.
- Advance (no stall, no flush): stage0 <= inputs, including lbr_data and valid_memory. stage[i] <= stage[i-1]. Latency is exactly PIPE_DEPTH cycles. Outputs come from stage[PIPE_DEPTH-1].
- Stall: all stages hold their value. Inputs are dropped; upstream must hold them. retired_count does not increment.
- Flush: every stage gets the reset values (valid 0, opwrite 0, NOP). retired_count is untouched. Flush wins over a simultaneous stall. Inputs presented on the flush edge are discarded.
- opwrite_writeback = stored opwrite AND stored valid. A bubble never writes the regfile, even if opwrite_memory was 1 with valid_memory 0.
- wb_data_writeback is combinational from the final stage: opsel 00 -> ALU_result, 01 -> load_data, 10 -> lbr_data, 11 -> 0. It is forced to 0 when valid_writeback=0.
- retired_count increments by 1 on each non-stalled, non-flushed, non-reset edge where the final stage is valid. This counts each instruction exactly once as it leaves. The counter wraps modulo 2^COUNT_WIDTH; there is no saturation.
- Reset mid-stall or mid-flush: reset dominates, and state clears on that edge.
- PIPE_DEPTH outside 1..4 is an elaboration error (generate-time check).
- No combinational path from any input to any output. wb_data depends only on registers.

Test Plan:
- Reset then advance, PIPE_DEPTH=1: reset 2 cycles -> instruction_writeback=32'h00000013, valid_writeback=0, retired_count=0. Drive ALU=0x1234, opsel=00, opwrite=1, valid=1, opReg=5 -> next cycle wb_data=0x1234, opwrite_writeback=1, opReg_writeback=5.
- LBR path: lbr_data_memory=0xDEADBEEF, opsel=10, valid=1 -> after 1 cycle lbr_data_writeback=0xDEADBEEF and wb_data=0xDEADBEEF. opsel=11 -> wb_data=0.
- Depth/latency, PIPE_DEPTH=3: push instructions I1,I2,I3 on consecutive cycles -> I1 appears on the 3rd edge, then I2 and I3 back-to-back. retired_count reaches 3 three edges after I3 is captured.
- Stall: hold stall=1 for 4 cycles while changing inputs -> outputs and retired_count frozen; on release the held contents resume in order.
- Flush vs stall: stall=1, flush=1 on the same edge with valid contents -> all stages become bubbles (valid 0, opwrite 0, instruction NOP); retired_count unchanged. Input opwrite=1, valid=0 -> opwrite_writeback=0.
- Counter wrap, COUNT_WIDTH=4: retire 17 valid instructions -> retired_count=1.
